// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Two-port AXI read arbiter: fetch (IF) and load/store (LS) share one AR/R channel.
// Define YSYX_22041071_AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed LS priority.
module ysyx_22041071_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4,
  parameter int IF_ID  = 0,
  parameter int LS_ID  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_ar_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [1:0]        if_size,
  output logic              if_ar_ready,
  output logic              if_r_valid,
  output logic [DATA_W-1:0] if_r_data,
  output logic [1:0]        if_r_resp,
  output logic              if_r_last,
  input  logic              ls_ar_valid,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [LEN_W-1:0]  ls_len,
  input  logic [1:0]        ls_size,
  output logic              ls_ar_ready,
  output logic              ls_r_valid,
  output logic [DATA_W-1:0] ls_r_data,
  output logic [1:0]        ls_r_resp,
  output logic              ls_r_last,
  output logic              m_ar_valid,
  output logic [ID_W-1:0]   m_ar_id,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LEN_W-1:0]  m_len,
  output logic [1:0]        m_size,
  input  logic              m_ar_ready,
  input  logic              m_r_valid,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_last,
  input  logic [ID_W-1:0]   m_r_id,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [ID_W-1:0] IF_ID_C = ID_W'(IF_ID);
  localparam logic [ID_W-1:0] LS_ID_C = ID_W'(LS_ID);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;   // 1 = LS port owns the channel
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        size_q, size_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              win_ls_s;
  logic [ID_W-1:0]   grant_id_s;
  logic              ar_hs_s;
  logic              beat_s;

`ifdef YSYX_22041071_AXI_RD_ARB_RR_EN
  logic              last_q, last_d;     // 1 = LS was served most recently
  // Under contention the port not served last wins.
  always_comb begin
    win_ls_s = ls_ar_valid & (~if_ar_valid | ~last_q);
  end
`else
  // Fixed priority: LS wins whenever it requests.
  always_comb begin
    win_ls_s = ls_ar_valid;
  end
`endif

  assign grant_id_s = grant_q ? LS_ID_C : IF_ID_C;

  // Next-state and datapath latch logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef YSYX_22041071_AXI_RD_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_ar_valid | ls_ar_valid) begin
          grant_d = win_ls_s;
          addr_d  = win_ls_s ? ls_addr : if_addr;
          len_d   = win_ls_s ? ls_len  : if_len;
          size_d  = win_ls_s ? ls_size : if_size;
          cnt_d   = '0;
          state_d = S_ADDR;
`ifdef YSYX_22041071_AXI_RD_ARB_RR_EN
          last_d  = win_ls_s;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (m_ar_ready) begin
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (m_r_valid) begin
          if (m_r_id == grant_id_s) begin
            cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
            // Last flag must coincide exactly with the final counted beat.
            if ((m_r_last & (cnt_q != len_q)) | (~m_r_last & (cnt_q == len_q))) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (m_r_last) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= 2'b00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef YSYX_22041071_AXI_RD_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef YSYX_22041071_AXI_RD_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs are gated by reset_n so nothing leaks while reset is asserted.
  assign m_ar_valid = reset_n & (state_q == S_ADDR);
  assign m_ar_id    = m_ar_valid ? grant_id_s : '0;
  assign m_addr     = m_ar_valid ? addr_q : '0;
  assign m_len      = m_ar_valid ? len_q : '0;
  assign m_size     = m_ar_valid ? size_q : 2'b00;

  assign ar_hs_s     = m_ar_valid & m_ar_ready;
  assign if_ar_ready = ar_hs_s & ~grant_q;
  assign ls_ar_ready = ar_hs_s & grant_q;

  assign beat_s     = reset_n & (state_q == S_DATA) & m_r_valid & (m_r_id == grant_id_s);
  assign if_r_valid = beat_s & ~grant_q;
  assign ls_r_valid = beat_s & grant_q;
  assign if_r_data  = if_r_valid ? m_r_data : '0;
  assign ls_r_data  = ls_r_valid ? m_r_data : '0;
  assign if_r_resp  = if_r_valid ? m_r_resp : 2'b00;
  assign ls_r_resp  = ls_r_valid ? m_r_resp : 2'b00;
  assign if_r_last  = if_r_valid & m_r_last;
  assign ls_r_last  = ls_r_valid & m_r_last;

  assign err = err_q;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Scoreboard bench for ysyx_22041071_axi_rd_arb: driver pushes expected AR/R traffic,
// a negedge monitor pops and compares whatever the arbiter presents.
module tb_ysyx_22041071_axi_rd_arb;

  localparam int IF_ID = 0;
  localparam int LS_ID = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_ar_valid, ls_ar_valid;
  logic [63:0] if_addr, ls_addr;
  logic [7:0]  if_len, ls_len;
  logic [1:0]  if_size, ls_size;
  logic        if_ar_ready, ls_ar_ready;
  logic        if_r_valid, ls_r_valid;
  logic [63:0] if_r_data, ls_r_data;
  logic [1:0]  if_r_resp, ls_r_resp;
  logic        if_r_last, ls_r_last;
  logic        m_ar_valid;
  logic [3:0]  m_ar_id;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  logic [1:0]  m_size;
  logic        m_ar_ready;
  logic        m_r_valid;
  logic [63:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic [3:0]  m_r_id;
  logic        err;

  ysyx_22041071_axi_rd_arb #(.ADDR_W(64), .DATA_W(64), .LEN_W(8), .ID_W(4),
                             .IF_ID(IF_ID), .LS_ID(LS_ID)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_ar_valid(if_ar_valid), .if_addr(if_addr), .if_len(if_len), .if_size(if_size),
    .if_ar_ready(if_ar_ready), .if_r_valid(if_r_valid), .if_r_data(if_r_data),
    .if_r_resp(if_r_resp), .if_r_last(if_r_last),
    .ls_ar_valid(ls_ar_valid), .ls_addr(ls_addr), .ls_len(ls_len), .ls_size(ls_size),
    .ls_ar_ready(ls_ar_ready), .ls_r_valid(ls_r_valid), .ls_r_data(ls_r_data),
    .ls_r_resp(ls_r_resp), .ls_r_last(ls_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_id(m_ar_id), .m_addr(m_addr), .m_len(m_len),
    .m_size(m_size), .m_ar_ready(m_ar_ready), .m_r_valid(m_r_valid), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_id(m_r_id), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {bit port; logic [3:0] id; logic [63:0] addr; logic [7:0] len; logic [1:0] size;} ar_t;
  typedef struct {bit port; logic [63:0] data; logic [1:0] resp; bit last;} r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  nvec = 0;
  int  nerr = 0;
  bit  err_exp = 1'b0;
  bit  last_served = 1'b1;
  logic [63:0] rq_addr[2];
  logic [7:0]  rq_len[2];
  logic [1:0]  rq_size[2];
  bit          fix_en = 1'b0;
  logic [63:0] fix_data = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arbitration rule from the requester's point of view.
  function automatic bit pick(input bit v_if, input bit v_ls);
    bit w;
`ifdef YSYX_22041071_AXI_RD_ARB_RR_EN
    w = (v_if && v_ls) ? ~last_served : v_ls;
`else
    w = v_ls;
`endif
    last_served = w;
    return w;
  endfunction

  // Monitor: compares every presented AR and R beat against the scoreboard queues.
  always @(negedge clk) begin
    ar_t a;
    r_t  r;
    bit  p;
    if (!reset_n) begin
      chk("rst_outs", 64'({m_ar_valid, if_ar_ready, ls_ar_ready, if_r_valid, ls_r_valid,
                           if_r_last, ls_r_last}), 64'h0);
      chk("rst_maddr", m_addr, 64'h0);
    end else begin
      if (m_ar_valid) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 64'h1, 64'h0);
        end else begin
          a = ar_q[0];
          chk("m_ar_id", 64'(m_ar_id), 64'(a.id));
          chk("m_addr", m_addr, a.addr);
          chk("m_len", 64'(m_len), 64'(a.len));
          chk("m_size", 64'(m_size), 64'(a.size));
          chk("if_ar_ready", 64'(if_ar_ready), 64'(m_ar_ready && !a.port));
          chk("ls_ar_ready", 64'(ls_ar_ready), 64'(m_ar_ready && a.port));
          if (m_ar_ready) void'(ar_q.pop_front());
        end
      end else begin
        chk("ar_ready_idle", 64'({if_ar_ready, ls_ar_ready}), 64'h0);
      end
      if (if_r_valid || ls_r_valid) begin
        chk("r_onehot", 64'(if_r_valid && ls_r_valid), 64'h0);
        if (r_q.size() == 0) begin
          chk("r_unexpected", 64'h1, 64'h0);
        end else begin
          r = r_q.pop_front();
          p = ls_r_valid;
          chk("r_port", 64'(p), 64'(r.port));
          chk("r_data", p ? ls_r_data : if_r_data, r.data);
          chk("r_resp", 64'(p ? ls_r_resp : if_r_resp), 64'(r.resp));
          chk("r_last", 64'(p ? ls_r_last : if_r_last), 64'(r.last));
          chk("r_other_zero", p ? {if_r_data[61:0], if_r_resp} : {ls_r_data[61:0], ls_r_resp}, 64'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    if_ar_valid = 1'b0; ls_ar_valid = 1'b0; m_ar_ready = 1'b0; m_r_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    err_exp = 1'b0;
    last_served = 1'b1;
    ar_q.delete();
    r_q.delete();
    chk("rst_err", 64'(err), 64'h0);
  endtask

  // mode: 0 normal, 1 foreign-ID beat before data, 2 last flag on first beat of a longer burst
  task automatic run_txn(input bit v_if, input bit v_ls, input int ar_dly, input int mode);
    bit  w;
    int  nb;
    ar_t a;
    r_t  r;
    if_ar_valid = v_if; if_addr = rq_addr[0]; if_len = rq_len[0]; if_size = rq_size[0];
    ls_ar_valid = v_ls; ls_addr = rq_addr[1]; ls_len = rq_len[1]; ls_size = rq_size[1];
    w = pick(v_if, v_ls);
    a.port = w; a.id = w ? 4'(LS_ID) : 4'(IF_ID);
    a.addr = rq_addr[w]; a.len = rq_len[w]; a.size = rq_size[w];
    ar_q.push_back(a);
    chk("lat_before", 64'(m_ar_valid), 64'h0);
    tick();
    chk("lat_one", 64'(m_ar_valid), 64'h1);
    if_ar_valid = 1'b0; ls_ar_valid = 1'b0;
    if_addr = {$urandom, $urandom}; ls_addr = {$urandom, $urandom};
    repeat (ar_dly) tick();
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    chk("ar_done", 64'(m_ar_valid), 64'h0);
    if (mode == 1) begin
      m_r_valid = 1'b1; m_r_id = 4'(2 + $urandom_range(0, 13));
      m_r_data = {$urandom, $urandom}; m_r_last = 1'($urandom); m_r_resp = 2'b00;
      tick();
      m_r_valid = 1'b0;
      err_exp = 1'b1;
    end
    nb = (mode == 2) ? 1 : int'(a.len) + 1;
    for (int b = 0; b < nb; b++) begin
      m_r_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      r.port = w;
      r.data = (fix_en && b == 0) ? fix_data : {$urandom, $urandom};
      r.resp = 2'($urandom);
      r.last = (mode == 2) ? 1'b1 : (b == nb - 1);
      r_q.push_back(r);
      m_r_valid = 1'b1; m_r_id = a.id; m_r_data = r.data; m_r_resp = r.resp; m_r_last = r.last;
      tick();
    end
    m_r_valid = 1'b0;
    if (mode == 2) err_exp = 1'b1;
    chk("err", 64'(err), 64'(err_exp));
    chk("ar_q_empty", 64'(ar_q.size()), 64'h0);
    chk("r_q_empty", 64'(r_q.size()), 64'h0);
  endtask

  initial begin
    bit vi, vl;
    int md;
    reset_n = 1'b0;
    if_ar_valid = 1'b0; ls_ar_valid = 1'b0;
    if_addr = 64'h0; ls_addr = 64'h0; if_len = 8'h0; ls_len = 8'h0; if_size = 2'b00; ls_size = 2'b00;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_data = 64'h0; m_r_resp = 2'b00; m_r_last = 1'b0; m_r_id = 4'h0;
    do_reset();
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'h0);

    // Single IF fetch, immediate handshake, one beat.
    rq_addr[0] = 64'h8000_0004; rq_len[0] = 8'd0; rq_size[0] = 2'b10;
    rq_addr[1] = 64'h0;         rq_len[1] = 8'd0; rq_size[1] = 2'b00;
    fix_en = 1'b1; fix_data = 64'hDEAD;
    run_txn(1'b1, 1'b0, 0, 0);
    fix_en = 1'b0;

    // LS burst of 4 with AR back-pressure.
    rq_addr[1] = 64'h0000_1000; rq_len[1] = 8'd3; rq_size[1] = 2'b11;
    run_txn(1'b0, 1'b1, 4, 0);

    // Contention right after reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rq_addr[0] = {$urandom, $urandom}; rq_addr[1] = {$urandom, $urandom};
      rq_len[0] = 8'($urandom_range(0, 2)); rq_len[1] = 8'($urandom_range(0, 2));
      run_txn(1'b1, 1'b1, 0, 0);
    end

    // Foreign ID beat while IF granted; err must stick.
    rq_len[0] = 8'd1;
    run_txn(1'b1, 1'b0, 1, 1);
    run_txn(1'b0, 1'b1, 0, 0);
    do_reset();

    // Early last on a two-beat burst.
    rq_len[1] = 8'd1;
    run_txn(1'b0, 1'b1, 0, 2);
    do_reset();

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < 2; p++) begin
        rq_addr[p] = {$urandom, $urandom};
        rq_len[p]  = 8'($urandom_range(1, 6));
        rq_size[p] = 2'($urandom);
      end
      vi = 1'($urandom); vl = 1'($urandom);
      if (!vi && !vl) vi = 1'b1;
      md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_txn(vi, vl, int'($urandom_range(0, 3)), md);
      if (md != 0) do_reset();
    end

    // Reset in the middle of an LS burst.
    do_reset();
    ls_ar_valid = 1'b1; ls_addr = 64'h2000; ls_len = 8'd3; ls_size = 2'b11;
    ar_q.push_back('{1'b1, 4'(LS_ID), 64'h2000, 8'd3, 2'b11});
    tick();
    ls_ar_valid = 1'b0;
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    r_q.push_back('{1'b1, 64'h1111, 2'b00, 1'b0});
    m_r_valid = 1'b1; m_r_id = 4'(LS_ID); m_r_data = 64'h1111; m_r_resp = 2'b00; m_r_last = 1'b0;
    tick();
    reset_n = 1'b0;
    m_r_data = 64'h2222;
    tick();
    reset_n = 1'b1;
    err_exp = 1'b0;
    chk("mid_rst_outs", 64'({m_ar_valid, ls_r_valid, if_r_valid, ls_ar_ready}), 64'h0);
    m_r_data = 64'h3333;
    tick();
    m_r_data = 64'h4444; m_r_last = 1'b1;
    tick();
    m_r_valid = 1'b0;
    chk("mid_rst_err", 64'(err), 64'h0);
    chk("mid_rst_rq", 64'(r_q.size()), 64'h0);
    chk("mid_rst_arq", 64'(ar_q.size()), 64'h0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
YSYX_22041071_AXI_RD_ARB -- requirements
Module: ysyx_22041071_axi_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: request address width.
REQ-002 SHALL have parameter DATA_W, default 64: read data width.
REQ-003 SHALL have parameter LEN_W, default 8: burst length field width (beats-1).
REQ-004 SHALL have parameter ID_W, default 4: AXI ID width.
REQ-005 SHALL have parameters IF_ID and LS_ID, defaults 0 and 1: IDs issued for the fetch and load ports.
REQ-006 SHALL have ports in this order:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- {if,ls}_ar_valid  in  1  requester read request
- {if,ls}_addr  in  ADDR_W  request address
- {if,ls}_len  in  LEN_W  burst beats-1
- {if,ls}_size  in  2  00=1B .. 11=8B
- {if,ls}_ar_ready  out  1  request accepted
- {if,ls}_r_valid  out  1  data beat to requester
- {if,ls}_r_data  out  DATA_W  beat data
- {if,ls}_r_resp  out  2  beat response
- {if,ls}_r_last  out  1  final beat
- m_ar_valid  out  1  request to shared read channel
- m_ar_id  out  ID_W  issued ID
- m_addr  out  ADDR_W  issued address
- m_len  out  LEN_W  issued length
- m_size  out  2  issued size
- m_ar_ready  in  1  shared channel accepts
- m_r_valid  in  1  beat from shared channel
- m_r_data  in  DATA_W  beat data
- m_r_resp  in  2  beat response
- m_r_last  in  1  final beat
- m_r_id  in  ID_W  beat ID
- err  out  1  sticky protocol error

Function
REQ-007 SHALL use three states: IDLE, ADDR, DATA; state, grant, request latches, beat counter registered.
REQ-008 IDLE: any requester ar_valid high -> latch winner's addr/len/size, grant := winner, beat count := 0, go ADDR next cycle; none -> stay.
REQ-009 ADDR: m_ar_valid=1 driving latched fields and grant's ID; fields stable until handshake.
REQ-010 ADDR: m_ar_valid & m_ar_ready -> granted port's ar_ready high that same cycle only, go DATA; otherwise hold.
REQ-011 Request-to-m_ar_valid latency SHALL be exactly 1 cycle.
REQ-012 ar_ready SHALL never be high outside ADDR handshake cycle; non-granted port ar_ready always 0.
REQ-013 DATA: m_r_valid with m_r_id == granted ID -> combinationally forward data/resp to granted port, r_valid=1, r_last=m_r_last; increment beat count.
REQ-014 DATA: beat with m_r_id != granted ID SHALL be dropped (no r_valid) and set err.
REQ-015 Beat with m_r_last=1 while count != latched len, or count == len with m_r_last=0, SHALL set err; beat still forwarded.
REQ-016 Accepted beat with m_r_last=1 -> IDLE next cycle; new grant earliest one cycle later (no back-to-back ADDR).
REQ-017 Non-granted port r_valid/r_last SHALL be 0; r_data/r_resp on it 0.
REQ-018 Requester dropping ar_valid during ADDR SHALL not abort; transaction completes and is delivered to that port.
REQ-019 Beat counter width LEN_W; wraps only if len = all-ones and count overflows (counts as err).
REQ-020 err SHALL stay 1 until reset.

Reset
REQ-021 reset_n=0 at clk edge -> state IDLE, grant := IF, last-served := LS, count 0, err 0, latched fields 0.
REQ-022 During/after reset all valid/ready/last outputs 0, m_* fields 0.
REQ-023 Reset mid-ADDR or mid-DATA SHALL abandon the transaction; beats arriving after reset ignored (state IDLE).

Configuration
REQ-024 Macro YSYX_22041071_AXI_RD_ARB_RR_EN defined: both requesting in IDLE -> grant port not last served (round robin); last-served updated at each grant; first contention after reset grants IF.
REQ-025 Macro undefined: both requesting -> LS always wins (fixed priority); last-served register absent.

Verification
REQ-026 IF only, addr=0x8000_0004, len=0, size=10, m_ar_ready high at once -> m_ar_valid cycle 1, m_addr=0x8000_0004, m_ar_id=0, if_ar_ready 1 cycle; beat 0xDEAD, last=1 -> if_r_valid=1, if_r_data=0xDEAD, ls_r_valid=0.
REQ-027 LS len=3, m_ar_ready delayed 4 cycles -> m_* stable 4 cycles, ls_ar_ready only on handshake; 4 beats forwarded, ls_r_last on 4th, err=0.
REQ-028 Both valid every IDLE, RR_EN defined -> grants IF, LS, IF, LS; undefined -> LS, LS, LS.
REQ-029 DATA with grant IF, beat m_r_id=1 -> no if/ls r_valid, err=1 held until reset.
REQ-030 len=1, m_r_last on first beat -> beat forwarded, err=1, return IDLE.
REQ-031 reset_n low mid-DATA of len=3 after 1 beat -> next cycle IDLE, outputs 0; remaining beats ignored.
